// File: rtl/addsub16_nibble_seq.sv
// ---------------------------------------------------------------------------
// addsub16_nibble_seq
//
// Multi-cycle WIDTH-bit two's-complement add/subtract unit. It has one 4-bit
// add/sub slice and uses it once per cycle, starting with the least significant
// nibble. The slice carry is held in a register between passes. The design can
// optionally saturate the result on signed overflow. It also reports
// zero/negative/overflow flags for the final result.
//
// Parameters:
//   WIDTH  operand/result width. It must be a multiple of 4 and at least 8.
//   NNIB   number of nibble passes, WIDTH/4. It is derived internally.
//
// Ports:
//   clk    in   1      clock, rising edge
//   rst    in   1      asynchronous, active-high reset
//   start  in   1      request an operation; sampled only while idle
//   A      in   WIDTH  first operand
//   B      in   WIDTH  second operand
//   sub    in   1      0: A+B, 1: A-B
//   sat    in   1      1: saturate the result on signed overflow
//   busy   out  1      high while an operation is running or completing
//   done   out  1      one-cycle pulse when Sum/flags are valid
//   Sum    out  WIDTH  result; holds its value between operations
//   Ovfl   out  1      signed overflow of the unsaturated result
//   Z      out  1      Sum == 0 (after saturation)
//   N      out  1      Sum sign bit (after saturation)
// ---------------------------------------------------------------------------
module addsub16_nibble_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    input  logic             sat,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Ovfl,
    output logic             Z,
    output logic             N
);

    localparam int NNIB = WIDTH / 4;
    localparam int CW   = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam logic [CW-1:0] LAST_NIB = CW'(NNIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sub_q;
    logic             sat_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             ovfl_q;
    logic             z_q;
    logic             n_q;
    logic             busy_q;
    logic             done_q;

    // Operand nibbles are arranged as arrays, so the slice inputs are
    // selected with a plain array index on the pass counter.
    logic [3:0] a_nib_w [NNIB];
    logic [3:0] b_nib_w [NNIB];

    logic [3:0] a_nib;
    logic [3:0] bx_nib;
    logic [4:0] nib_sum;
    logic       carry_into_msb;
    logic       ovfl_w;
    logic [WIDTH-1:0] sat_val;

    for (genvar gi = 0; gi < NNIB; gi++) begin : g_nib
        assign a_nib_w[gi] = a_q[gi*4 +: 4];
        assign b_nib_w[gi] = b_q[gi*4 +: 4];
        // Only the nibble that is currently addressed takes the slice output.
        // The other nibbles keep their previous contents.
        assign res_d[gi*4 +: 4] = (cnt_q == CW'(gi)) ? nib_sum[3:0]
                                                     : res_q[gi*4 +: 4];
    end

    // Shared 4-bit slice. For subtraction, B is inverted here. The +1 comes
    // from the carry register, which is preset to 'sub' when a start is accepted.
    assign a_nib   = a_nib_w[cnt_q];
    assign bx_nib  = b_nib_w[cnt_q] ^ {4{sub_q}};
    assign nib_sum = {1'b0, a_nib} + {1'b0, bx_nib} + {4'b0000, carry_q};

    // Carry into bit 3 of the slice. This is recovered from the sum bit: s = a ^ b ^ cin.
    // In the top nibble, this bit is the carry into the sign bit.
    assign carry_into_msb = nib_sum[3] ^ a_nib[3] ^ bx_nib[3];
    assign ovfl_w         = carry_into_msb ^ nib_sum[4];

    // An overflowed result saturates toward the sign of A. When there is an
    // overflow, A and the effective B have the same sign.
    assign sat_val = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                  : {1'b0, {(WIDTH-1){1'b1}}};

    assign sum_d = (sat_q && ovfl_w) ? sat_val : res_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            sum_q   <= '0;
            ovfl_q  <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        sub_q   <= sub;
                        sat_q   <= sat;
                        cnt_q   <= '0;
                        carry_q <= sub;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end

                S_RUN: begin
                    res_q   <= res_d;
                    carry_q <= nib_sum[4];
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST_NIB) begin
                        // The visible outputs change only here. This means no
                        // partial result is ever shown.
                        cnt_q   <= '0;
                        sum_q   <= sum_d;
                        ovfl_q  <= ovfl_w;
                        z_q     <= (sum_d == '0);
                        n_q     <= sum_d[WIDTH-1];
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end

                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Sum  = sum_q;
    assign Ovfl = ovfl_q;
    assign Z    = z_q;
    assign N    = n_q;

endmodule

// File: doc/addsub16_nibble_seq.md
Name: addsub16_nibble_seq

Overview:
- Multi-cycle WIDTH-bit signed add/subtract unit built from one shared 4-bit add/sub slice.
- The slice processes one nibble per cycle, LSB nibble first, with the carry held in a register between cycles.
- Used in the ALU area wherever a full-width adder costs too much area and the multi-cycle latency is acceptable.
- Adds an optional saturation mode and zero/negative/overflow flags.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of 4 and at least 8.
- NNIB, WIDTH/4, number of nibble passes; derived, not overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- A  input  WIDTH  first operand, two's complement.
- B  input  WIDTH  second operand, two's complement.
- sub  input  1  0 = A+B, 1 = A-B.
- sat  input  1  1 = saturate the result on signed overflow.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when the result is valid.
- Sum  output  WIDTH  result; held until the next accepted start.
- Ovfl  output  1  signed overflow of the unsaturated result.
- Z  output  1  Sum == 0 (post-saturation).
- N  output  1  Sum[WIDTH-1] (post-saturation).

Behaviour:
- Reset (asynchronous, any state, including mid-RUN):
  - state = IDLE, nibble counter = 0, carry register = 0.
  - busy = done = Ovfl = Z = N = 0, Sum = 0.
  - Latched operands are discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1: latch A, B, sub and sat; set cnt = 0; set carry register = sub; go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - Each edge computes nibble cnt = A_l[cnt] + (sub_l ? ~B_l[cnt] : B_l[cnt]) + carry.
  - The result is written into an internal result register at nibble cnt.
  - The carry register takes the nibble carry-out.
  - cnt increments each edge.
  - When cnt == NNIB-1:
    - Record Ovfl = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
    - Apply saturation.
    - Update Sum, Z and N; go to DONE.
- Saturation:
  - Applies only if sat_l=1 and overflow occurred.
  - Sum = 0111..1 if A_l[WIDTH-1] == 0, otherwise 1000..0.
  - In all other cases Sum = the raw wrapped result.
  - Ovfl reports overflow regardless of sat.
- DONE:
  - done = 1 for exactly one cycle; next edge goes to IDLE unconditionally.
  - start is ignored in this state.
- Latency: start accepted at edge k → done high during the cycle after edge k+NNIB (5 edges for WIDTH=16).
  - Back-to-back throughput: one operation per NNIB+2 cycles.
- Output timing:
  - Sum, Ovfl, Z and N update only on the final RUN edge.
  - They do not update during intermediate nibbles; no partial results are visible.
- start while busy (RUN or DONE): ignored. No queueing, and operands are not re-sampled.
- Operand inputs may change freely after the accepting edge.
- Wrap-around: with sat=0, results wrap modulo 2^WIDTH.

Test Plan:
1. A=0x1234, B=0x0FFF, sub=0, sat=0, start pulse → done asserted in the cycle after the 5th edge; Sum=0x2233, Ovfl=0, Z=0, N=0; busy high for 5 cycles.
2. A=0x7FFF, B=0x0001, sub=0:
   - sat=0 → Sum=0x8000, Ovfl=1, N=1.
   - sat=1 → Sum=0x7FFF, Ovfl=1, N=0.
3. A=0x8000, B=0x0001, sub=1:
   - sat=0 → Sum=0x7FFF, Ovfl=1.
   - sat=1 → Sum=0x8000, Ovfl=1, N=1.
4. A=0x0005, B=0x0005, sub=1 → Sum=0x0000, Z=1, Ovfl=0. Then A=0xFFFF, B=0x0001, sub=0 → Sum=0x0000, Z=1, Ovfl=0 (carry out ignored).
5. Start A=0x0001, B=0x0002; during RUN pulse start with A=0x1111, B=0x1111 → exactly one done pulse, Sum=0x0003. A new start accepted in IDLE works normally.
6. Assert rst asynchronously on the 3rd RUN cycle → busy, done, Sum, Ovfl, Z and N are 0 immediately, with no done pulse. After release, A=0x00FF, B=0x0001 add → Sum=0x0100.
